// File: rtl/debounce_pkg.sv
// Shared constants, width helper and per-channel output bundle for multi_debouncer.
package debounce_pkg;

    localparam int DEF_TICK_COUNT  = 5000000;
    localparam int DEF_LONG_TICKS  = 50000000;
    localparam int DEF_SYNC_STAGES = 2;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic held;
    } chan_out_t;

    function automatic int cnt_width(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter, level and pulse registers.
// Optional hold counter for long_press when MULTI_DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int TICK_COUNT  = DEF_TICK_COUNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
    input  logic      clk_100Mhz,
    input  logic      reset_n,
    input  logic      btn_raw,
    output chan_out_t chan_out
);

    localparam int              CW      = cnt_width(TICK_COUNT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   level_reg;
    logic                   press_reg;
    logic                   release_reg;
    logic                   long_pulse;
    logic                   sync;

    assign sync = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Any cycle where sync agrees with the held level restarts the stability count.
    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (sync == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg     <= '0;
                level_reg   <= sync;
                press_reg   <= sync;
                release_reg <= ~sync;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam int            HW       = cnt_width(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hcnt_reg;
    logic          long_reg;

    // Saturating at HOLD_MAX guarantees a single pulse per press.
    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_reg <= '0;
            long_reg <= 1'b0;
        end else if (!level_reg) begin
            hcnt_reg <= '0;
            long_reg <= 1'b0;
        end else if (hcnt_reg != HOLD_MAX) begin
            hcnt_reg <= hcnt_reg + 1'b1;
            long_reg <= (hcnt_reg == HOLD_MAX - 1'b1);
        end else begin
            long_reg <= 1'b0;
        end
    end

    assign long_pulse = long_reg;
`else
    // LONG_TICKS stays in the parameter list but has no effect in this build.
    assign long_pulse = 1'b0 && (LONG_TICKS > 0);
`endif

    assign chan_out.level = level_reg;
    assign chan_out.press = press_reg;
    assign chan_out.rel   = release_reg;
    assign chan_out.held  = long_pulse;

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: CHANNELS independent debounce_channel instances.
// Long-press pulses are built only when MULTI_DEBOUNCER_LONG_PRESS_EN is defined.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int TICK_COUNT  = DEF_TICK_COUNT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LONG_TICKS  = DEF_LONG_TICKS
) (
    input  logic                clk_100Mhz,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] long_press
);

    chan_out_t chan_out [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            debounce_channel #(
                .TICK_COUNT  (TICK_COUNT),
                .SYNC_STAGES (SYNC_STAGES),
                .LONG_TICKS  (LONG_TICKS)
            ) u_chan (
                .clk_100Mhz (clk_100Mhz),
                .reset_n    (reset_n),
                .btn_raw    (btn_in[gi]),
                .chan_out   (chan_out[gi])
            );

            assign btn_level[gi]   = chan_out[gi].level;
            assign btn_press[gi]   = chan_out[gi].press;
            assign btn_release[gi] = chan_out[gi].rel;
            assign long_press[gi]  = chan_out[gi].held;
        end
    endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: directed scenarios plus randomized
// bouncing inputs compared against a run-length reference model.
module tb_multi_debouncer;

    localparam int CH = 4;
    localparam int TC = 4;
    localparam int SS = 2;
    localparam int LT = 10;

    logic          clk_100Mhz = 1'b0;
    logic          reset_n;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_press;
    logic [CH-1:0] btn_release;
    logic [CH-1:0] long_press;

    int total = 0;
    int bad   = 0;

    multi_debouncer #(
        .CHANNELS    (CH),
        .TICK_COUNT  (TC),
        .SYNC_STAGES (SS),
        .LONG_TICKS  (LT)
    ) dut (
        .clk_100Mhz  (clk_100Mhz),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .long_press  (long_press)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    // Reference model: input delayed by the synchroniser depth, a run of TC
    // consecutive disagreeing samples flips the level, hold time counted in cycles.
    bit pipe [CH][$];
    bit m_lvl   [CH];
    int m_run   [CH];
    int m_hold  [CH];
    bit m_press [CH];
    bit m_rel   [CH];
    bit m_long  [CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            pipe[c].delete();
            for (int s = 0; s < SS; s++) pipe[c].push_back(1'b0);
            m_lvl[c] = 0; m_run[c] = 0; m_hold[c] = 0;
            m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] v);
        for (int c = 0; c < CH; c++) begin
            bit seen;
            bit old;
            seen = pipe[c].pop_front();
            pipe[c].push_back(v[c]);
            old = m_lvl[c];
            m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
            if (old) begin
                if (m_hold[c] < LT) begin
                    m_hold[c]++;
                    if (m_hold[c] == LT) m_long[c] = 1;
                end
            end else begin
                m_hold[c] = 0;
            end
`ifndef MULTI_DEBOUNCER_LONG_PRESS_EN
            m_long[c] = 0;
`endif
            if (seen != old) begin
                m_run[c]++;
                if (m_run[c] == TC) begin
                    m_lvl[c]   = seen;
                    m_press[c] = seen;
                    m_rel[c]   = !seen;
                    m_run[c]   = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [CH-1:0] el, ep, er, elp;
        for (int c = 0; c < CH; c++) begin
            el[c] = m_lvl[c]; ep[c] = m_press[c]; er[c] = m_rel[c]; elp[c] = m_long[c];
        end
        check_val({tag, "_level"},   32'(btn_level),   32'(el));
        check_val({tag, "_press"},   32'(btn_press),   32'(ep));
        check_val({tag, "_release"}, 32'(btn_release), 32'(er));
        check_val({tag, "_long"},    32'(long_press),  32'(elp));
    endtask

    task automatic cycle(input logic [CH-1:0] v, input string tag);
        btn_in = v;
        @(posedge clk_100Mhz);
        if (reset_n) model_step(v);
        @(negedge clk_100Mhz);
        compare_all(tag);
    endtask

    // Apply v and count edges until the selected output mask goes nonzero.
    task automatic edges_until(input logic [CH-1:0] v, input int sel, input logic [CH-1:0] mask,
                               input string tag, output int n, output logic [CH-1:0] seen_vec);
        n = 0;
        seen_vec = '0;
        for (int i = 0; i < 40; i++) begin
            logic [CH-1:0] o;
            cycle(v, tag);
            n++;
            o = (sel == 0) ? btn_press : btn_release;
            if ((o & mask) != 0) begin
                seen_vec = o;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [CH-1:0] vec;
        logic [CH-1:0] v;
        int rise_at, long_at, longs;
        int hold_left [CH];

        reset_n = 1'b0;
        btn_in  = '0;
        model_reset();
        repeat (3) @(negedge clk_100Mhz);
        compare_all("rst");
        reset_n = 1'b1;
        repeat (4) cycle('0, "idle");

        // 1: clean press and release on channel 0
        edges_until(4'b0001, 0, 4'b0001, "s1", n, vec);
        check_val("s1_press_latency", n, SS + TC);
        check_val("s1_press_vec", 32'(vec), 32'h1);
        repeat (20) cycle(4'b0001, "s1_hold");
        edges_until(4'b0000, 1, 4'b0001, "s1r", n, vec);
        check_val("s1_release_latency", n, SS + TC);
        check_val("s1_release_vec", 32'(vec), 32'h1);
        $display("scenario 1 clean press/release done");

        // 2: bounce on channel 1 never reaches TC consecutive samples
        v = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            v[1] = (i % 4 != 3);
            cycle(v, "s2");
            check_val("s2_level1", 32'(btn_level[1]), 0);
        end
        repeat (8) begin
            cycle(4'b0000, "s2_quiet");
            check_val("s2_activity", 32'(btn_press | btn_release | btn_level), 0);
        end
        $display("scenario 2 bounce rejection done");

        // 3: long press on channel 2
        rise_at = -1; long_at = -1; longs = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'b0100, "s3");
            if (btn_level[2] && rise_at < 0) rise_at = i;
            if (long_press[2]) begin longs++; long_at = i; end
        end
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
        check_val("s3_long_count", longs, 1);
        check_val("s3_long_delay", long_at - rise_at, LT);
`else
        check_val("s3_long_count", longs, 0);
`endif
        repeat (10) cycle(4'b0000, "s3_rel");
        $display("scenario 3 long press done rise=%0d long=%0d", rise_at, long_at);

        // 4: all channels together, then only channel 3 released
        edges_until(4'b1111, 0, 4'b1111, "s4", n, vec);
        check_val("s4_press_latency", n, SS + TC);
        check_val("s4_press_vec", 32'(vec), 32'hF);
        repeat (3) cycle(4'b1111, "s4_hold");
        edges_until(4'b0111, 1, 4'b1111, "s4r", n, vec);
        check_val("s4_release_vec", 32'(vec), 32'h8);
        check_val("s4_level_after", 32'(btn_level), 32'h7);
        repeat (10) cycle(4'b0000, "s4_idle");
        $display("scenario 4 simultaneous channels done");

        // 5: reset in the middle of a count, with channel 1 already pressed
        repeat (8) cycle(4'b0010, "s5_pre");
        check_val("s5_pre_level", 32'(btn_level), 32'h2);
        repeat (4) cycle(4'b0011, "s5_count");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("s5_async");
        check_val("s5_async_level", 32'(btn_level), 0);
        repeat (4) cycle(4'b0011, "s5_inrst");
        reset_n = 1'b1;
        edges_until(4'b0011, 0, 4'b0001, "s5", n, vec);
        check_val("s5_press_latency", n, SS + TC);
        check_val("s5_press_vec", 32'(vec), 32'h3);
        repeat (10) cycle(4'b0000, "s5_idle");
        $display("scenario 5 reset mid-count done");

        // 6: three-cycle pulse is too short, a following long hold is accepted
        repeat (3) cycle(4'b1000, "s6_short");
        repeat (6) begin
            cycle(4'b0000, "s6_gap");
            check_val("s6_no_press", 32'(btn_press[3] | btn_level[3]), 0);
        end
        edges_until(4'b1000, 0, 4'b1000, "s6", n, vec);
        check_val("s6_press_latency", n, SS + TC);
        repeat (10) cycle(4'b0000, "s6_idle");
        $display("scenario 6 sub-threshold pulse done");

        // Randomized bouncing inputs against the model
        v = '0;
        for (int c = 0; c < CH; c++) hold_left[c] = 1;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < CH; c++) begin
                hold_left[c]--;
                if (hold_left[c] == 0) begin
                    v[c] = ~v[c];
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 20))
                                                               : int'($urandom_range(1, 5));
                end
            end
            cycle(v, "rnd");
        end
        $display("random phase done cycles=2000");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised, multi-channel successor to the single-button debouncer in the morse front end. Each channel synchronises a raw button or key input, filters contact bounce with a per-channel stability counter, and holds a clean debounced level. On every accepted transition it emits a one-cycle press or release pulse. An optional long-press detector gives the morse decoder dot/dash and word-gap hints without a separate timer.

## Interface
- `CHANNELS`, default 4: number of independent inputs; must be ≥1.
- `TICK_COUNT`, default 5000000: consecutive stable cycles needed to accept a transition (50 ms at 100 MHz); must be ≥1.
- `SYNC_STAGES`, default 2: synchroniser flop depth per channel; must be ≥2.
- `LONG_TICKS`, default 50000000: cycles of held level before `long_press` fires (0.5 s); must be ≥1. Used only with `MULTI_DEBOUNCER_LONG_PRESS_EN`.
- `clk_100Mhz`, input, 1 bit: single clock, 100 MHz.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `btn_in`, input, CHANNELS bits: raw, asynchronous, bouncy inputs. Active-high (1 = pressed).
- `btn_level`, output, CHANNELS bits: debounced level.
- `btn_press`, output, CHANNELS bits: one-cycle pulse on an accepted 0→1 transition.
- `btn_release`, output, CHANNELS bits: one-cycle pulse on an accepted 1→0 transition.
- `long_press`, output, CHANNELS bits: one-cycle pulse when held for LONG_TICKS cycles. Tied to 0 without the macro.

## Operation
- Each channel is fully independent; there is no shared state between channels.
- **Synchroniser:** `btn_in[i]` passes through a SYNC_STAGES-deep flop chain. The last stage is `sync[i]`.
- **Stability counter:** `cnt`, width `$clog2(TICK_COUNT)` (minimum 1 bit). Each cycle:
  - If `sync == level`: set `cnt <= 0`.
  - Otherwise, if `cnt == TICK_COUNT-1`: set `level <= sync` and `cnt <= 0`, and assert `btn_press` (new level 1) or `btn_release` (new level 0) for one cycle.
  - Otherwise: `cnt <= cnt + 1`.
- The counter never wraps. It is cleared before it can exceed TICK_COUNT-1.
- A bounce, meaning any cycle where `sync` equals `level` again, restarts the count from 0.
- `btn_press` and `btn_release` are mutually exclusive per channel and never back-to-back. After any accepted transition, the next one needs at least TICK_COUNT further cycles.
- **Long press (macro on):**
  - Hold counter `hcnt`, width `$clog2(LONG_TICKS+1)`, saturates at LONG_TICKS.
  - Cleared while `level == 0`; increments while `level == 1`.
  - `long_press` pulses on the single cycle `hcnt` reaches LONG_TICKS, i.e. LONG_TICKS cycles after `level` rose.
  - It fires at most once per press; saturation prevents any repeat.
- **Reset:** all flops clear asynchronously. While `reset_n` is low, every output is 0.
- **Reset mid-count:** the count is discarded. After reset releases, a held input produces `btn_press` SYNC_STAGES+TICK_COUNT cycles later.

## Timing
- All outputs are registered with no combinational path from `btn_in`.
- **Latency:** an input change that is stable before clock edge 0 updates `btn_level` and pulses `btn_press`/`btn_release` after edge SYNC_STAGES+TICK_COUNT, in the same cycle.
- Pulse width is exactly 1 cycle and coincides with the first cycle of the new `btn_level`.
- Reset values: `btn_level`, `btn_press`, `btn_release` and `long_press` are all 0. Synchroniser, `cnt` and `hcnt` are all 0.
- If `reset_n` deasserts on the same edge an input changes, that input enters the synchroniser on the first post-reset edge.

## Configuration
- Macro: `MULTI_DEBOUNCER_LONG_PRESS_EN`.
- **Defined:** the hold counters and `long_press` logic are built as described above.
- **Undefined:** no hold counters exist, `long_press` is constant 0, and LONG_TICKS is ignored. All other behaviour is identical.

## Structure
- **Package `debounce_pkg`:**
  - Default constants `DEF_TICK_COUNT = 5000000`, `DEF_LONG_TICKS = 50000000`, `DEF_SYNC_STAGES = 2`.
  - Function `cnt_width(int n)` that returns `max(1, $clog2(n))`.
- **Sub-module `debounce_channel`:** one channel, containing the synchroniser, stability counter, level register, pulse registers and optional hold counter. The top level instantiates it CHANNELS times in a generate loop and only concatenates the outputs.

## Test plan
Parameters for all scenarios: CHANNELS=4, TICK_COUNT=4, SYNC_STAGES=2, LONG_TICKS=10. The macro is defined unless stated otherwise.

1. **Clean press and release:** raise `btn_in[0]` before edge 0 and hold. → `btn_level[0]` rises after edge 6 and `btn_press[0]=1` for exactly that cycle; the other channels stay 0. Drop it 20 cycles later → `btn_release[0]` pulses 6 edges after the drop.
2. **Bounce rejection:** toggle `btn_in[1]` 1,1,1,0,1,1,1,0 with each value held one cycle. → No `btn_level`, `btn_press` or `btn_release` activity.
3. **Long press:** hold `btn_in[2]` for 30 cycles. → `long_press[2]` pulses exactly once, 10 cycles after `btn_level[2]` rose. With the macro undefined → `long_press` stays 0 throughout.
4. **Simultaneous channels:** raise all four inputs on the same edge. → All `btn_press` bits pulse together after edge 6. Releasing channel 3 alone → only `btn_release[3]` pulses.
5. **Reset mid-count:** raise `btn_in[0]` and pull `reset_n` low at edge 4. → All outputs read 0 immediately, asynchronously. Release reset at edge 8 with the input still high → `btn_press[0]` pulses 6 edges after release.
6. **Sub-threshold pulse:** hold `btn_in[3]` high for 3 cycles, then low. → No press; the counter returns to 0, and a following 4+ cycle hold is accepted with full 6-edge latency.
